// File: rtl/dff_pkg.sv
// Shared definitions for the dff_pipe register pipeline.
// Holds the occupancy-width helper and the default reset/clear data bit.
// No logic; imported by every file of the block.
package dff_pkg;

    // Every bit of the default reset/clear data word takes this value.
    localparam logic DFF_RST_BIT = 1'b0;

    // Bits needed to count 0..depth inclusive.
    function automatic int clog2_p1(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready/data bundle used on both sides of the pipeline.
// master drives valid/data and samples ready; slave does the opposite.
// No storage; a transfer happens on any rising edge with valid & ready.
interface dff_pipe_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/dff_stage.sv
// One pipeline stage: valid flag plus data register, async reset, sync clear.
// Latency: one cycle from load to the registered v/d outputs.
// Backpressure: space is combinational from dn_rdy, so it forms one link of the ready chain.
//
// Ports: up_vld/up_dat  beat offered by the previous stage (or the producer)
//        dn_rdy         next stage has space (or the consumer is ready)
//        v/d            registered valid flag and data
//        space          this stage can load on the next edge
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_BIT}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             dn_rdy,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             space
);

    logic             v_q;
    logic             v_d;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] d_d;
    logic             go;

    always_comb begin
        // go: the held beat leaves this stage on the coming edge.
        go    = v_q & dn_rdy;
        space = ~v_q | go;
        v_d   = v_q;
        d_d   = d_q;
        if (clear) begin
            v_d = 1'b0;
            d_d = RST_VAL;
        end else if (up_vld & space) begin
            v_d = 1'b1;
            d_d = up_dat;
        end else if (go) begin
            // Emptying without a refill keeps the stale data word.
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= 1'b0;
            d_q <= RST_VAL;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v = v_q;
    assign d = d_q;

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage registered pipeline with valid/ready on both sides, bubble collapse,
// synchronous clear, programmable reset value and occupancy count.
// Latency: DEPTH-1 cycles after the accept edge on an empty pipe; 1 beat/cycle throughput.
// Backpressure: in_ready is combinational from out_ready through every stage; bubbles fill.
//
// Ports: clk, reset (async, active-low), clear (sync flush)
//        in_if   producer side (slave): valid/data in, ready out
//        out_if  consumer side (master): valid/data out, ready in
//        occupancy  number of stages holding a beat, 0..DEPTH
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{DFF_RST_BIT}}
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    dff_pipe_if.slave                        in_if,
    dff_pipe_if.master                       out_if,
    output logic [clog2_p1(DEPTH)-1:0]       occupancy
);

    localparam int OCC_W = clog2_p1(DEPTH);

    logic             stg_v     [DEPTH];
    logic [WIDTH-1:0] stg_d     [DEPTH];
    logic             stg_space [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;
        logic             dn_rdy;

        // Stage 0 needs no clear gating: clear already wins inside the stage.
        if (k == 0) begin : g_head
            assign up_vld = in_if.valid;
            assign up_dat = in_if.data;
        end else begin : g_body
            assign up_vld = stg_v[k-1];
            assign up_dat = stg_d[k-1];
        end

        if (k == DEPTH - 1) begin : g_tail
            assign dn_rdy = out_if.ready;
        end else begin : g_mid
            assign dn_rdy = stg_space[k+1];
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .clear  (clear),
            .up_vld (up_vld),
            .up_dat (up_dat),
            .dn_rdy (dn_rdy),
            .v      (stg_v[k]),
            .d      (stg_d[k]),
            .space  (stg_space[k])
        );
    end

    assign in_if.ready  = stg_space[0] & ~clear;
    assign out_if.valid = stg_v[DEPTH-1];
    assign out_if.data  = stg_d[DEPTH-1];

    // Occupancy depends on the valid registers only, never on the handshakes.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(stg_v[k]);
        end
    end

endmodule

// File: tb/tb_dff_pipe.sv
`timescale 1ns/1ps
module tb_dff_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset3, reset1, clear3, clear1;
    logic [1:0] occ3;
    logic       occ1;

    dff_pipe_if #(.WIDTH(4)) i3 ();
    dff_pipe_if #(.WIDTH(4)) o3 ();
    dff_pipe_if #(.WIDTH(4)) i1 ();
    dff_pipe_if #(.WIDTH(4)) o1 ();

    dff_pipe #(.WIDTH(4), .DEPTH(3), .RST_VAL(4'h0)) u_dut3 (
        .clk(clk), .reset(reset3), .clear(clear3),
        .in_if(i3), .out_if(o3), .occupancy(occ3)
    );

    dff_pipe #(.WIDTH(4), .DEPTH(1), .RST_VAL(4'hA)) u_dut1 (
        .clk(clk), .reset(reset1), .clear(clear1),
        .in_if(i1), .out_if(o1), .occupancy(occ1)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a pipeline of DEPTH registers is an order-preserving
    // queue holding at most DEPTH beats; ready is withheld only when it is
    // full and the consumer stalls, or during clear.
    int  q3[$], t3[$], q1[$], t1[$];
    bit  lat3 = 0, lat1 = 0;
    int  acc1 = 0;

    always @(negedge clk) begin
        int tt;
        if (reset3) begin
            chk("occ3_vs_model", int'(occ3), q3.size());
            chk("in_ready3_rule", int'(i3.ready),
                int'(!clear3 && (q3.size() < 3 || o3.ready)));
            if (q3.size() == 0) chk("empty3_no_valid", int'(o3.valid), 0);
            if (o3.valid && o3.ready) begin
                chk("out3_has_beat", int'(q3.size() > 0), 1);
                if (q3.size() > 0) begin
                    chk("out3_data", int'(o3.data), q3.pop_front());
                    tt = t3.pop_front();
                    if (lat3) chk("lat3", cyc - tt, 3);
                end
            end
            if (clear3) begin
                q3.delete();
                t3.delete();
            end else if (i3.valid && i3.ready) begin
                q3.push_back(int'(i3.data));
                t3.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        int tt;
        if (reset1) begin
            chk("occ1_vs_model", int'(occ1), q1.size());
            chk("in_ready1_rule", int'(i1.ready),
                int'(!clear1 && (q1.size() < 1 || o1.ready)));
            if (q1.size() == 0) chk("empty1_no_valid", int'(o1.valid), 0);
            if (o1.valid && o1.ready) begin
                chk("out1_has_beat", int'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    chk("out1_data", int'(o1.data), q1.pop_front());
                    tt = t1.pop_front();
                    if (lat1) chk("lat1", cyc - tt, 1);
                end
            end
            if (clear1) begin
                q1.delete();
                t1.delete();
            end else if (i1.valid && i1.ready) begin
                q1.push_back(int'(i1.data));
                t1.push_back(cyc);
                acc1++;
            end
        end
    end

    task automatic push3(input logic [3:0] dv);
        int n = 0;
        i3.valid = 1'b1;
        i3.data  = dv;
        @(negedge clk);
        while (!i3.ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("push3_accepted", int'(i3.ready), 1);
        @(posedge clk); #1;
        i3.valid = 1'b0;
    endtask

    task automatic drain3;
        int n = 0;
        i3.valid = 1'b0;
        o3.ready = 1'b1;
        while (q3.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain3_empty", q3.size(), 0);
    endtask

    task automatic drain1;
        int n = 0;
        i1.valid = 1'b0;
        o1.ready = 1'b1;
        while (q1.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain1_empty", q1.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        reset3 = 0; reset1 = 0; clear3 = 0; clear1 = 0;
        i3.valid = 0; i3.data = 0; o3.ready = 0;
        i1.valid = 0; i1.data = 0; o1.ready = 0;
        #12;
        chk("rst3_out_valid", int'(o3.valid), 0);
        chk("rst3_out_data",  int'(o3.data), 0);
        chk("rst3_occ",       int'(occ3), 0);
        chk("rst3_in_ready",  int'(i3.ready), 1);
        chk("rst1_out_data",  int'(o1.data), 10);
        chk("rst1_out_valid", int'(o1.valid), 0);
        @(posedge clk); #3;
        reset3 = 1; reset1 = 1;
        @(posedge clk); #1;

        // Stream: 1..8 back-to-back with the consumer always ready.
        o3.ready = 1; lat3 = 1;
        for (int k = 1; k <= 8; k++) push3(4'(k));
        drain3();
        lat3 = 0;

        // Backpressure: three fill the pipe, the fourth waits.
        o3.ready = 0;
        push3(4'h3); push3(4'h5); push3(4'h7);
        i3.valid = 1; i3.data = 4'h9;
        repeat (2) @(negedge clk);
        chk("bp_full_occ", int'(occ3), 3);
        chk("bp_full_in_ready", int'(i3.ready), 0);
        @(posedge clk); #1;
        o3.ready = 1;
        @(negedge clk);
        chk("bp_release_in_ready", int'(i3.ready), 1);
        @(posedge clk); #1;
        i3.valid = 0;
        drain3();

        // Bubble collapse: A, idle cycle, B with consumer stalled.
        o3.ready = 0;
        push3(4'hA);
        @(posedge clk); #1;
        push3(4'hB);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bubble_occ", int'(occ3), 2);
        chk("bubble_out_valid", int'(o3.valid), 1);
        chk("bubble_out_data", int'(o3.data), 10);
        chk("bubble_in_ready", int'(i3.ready), 1);

        // Clear with an offered beat that must be refused.
        @(posedge clk); #1;
        clear3 = 1; i3.valid = 1; i3.data = 4'hE;
        @(negedge clk);
        chk("clr_in_ready", int'(i3.ready), 0);
        @(posedge clk); #1;
        clear3 = 0; i3.valid = 0;
        @(negedge clk);
        chk("clr_occ", int'(occ3), 0);
        chk("clr_out_valid", int'(o3.valid), 0);
        chk("clr_out_data", int'(o3.data), 0);

        // Async reset while full, asserted between edges.
        @(posedge clk); #1;
        o3.ready = 0;
        push3(4'h1); push3(4'h2); push3(4'h3);
        @(negedge clk);
        chk("pre_rst_occ", int'(occ3), 3);
        #2;
        reset3 = 0;
        q3.delete(); t3.delete();
        #1;
        chk("arst_out_valid", int'(o3.valid), 0);
        chk("arst_out_data", int'(o3.data), 0);
        chk("arst_occ", int'(occ3), 0);
        @(posedge clk); #3;
        reset3 = 1;
        @(posedge clk); #1;
        o3.ready = 1; lat3 = 1;
        push3(4'h6); push3(4'hC);
        drain3();
        lat3 = 0;

        // DEPTH=1: full with consumer ready sustains one beat per cycle.
        o1.ready = 1; lat1 = 1; a0 = acc1;
        for (int k = 0; k < 10; k++) begin
            i1.valid = 1; i1.data = 4'(k + 3);
            @(negedge clk);
            if (k > 0) begin
                chk("d1_full_occ", int'(occ1), 1);
                chk("d1_full_in_ready", int'(i1.ready), 1);
            end
            @(posedge clk); #1;
        end
        i1.valid = 0;
        chk("d1_accepts", acc1 - a0, 10);
        drain1();
        lat1 = 0;

        // Random traffic on both pipes, occasional clear.
        for (int c = 0; c < 400; c++) begin
            i3.valid = 1'($urandom_range(0, 1));
            i3.data  = 4'($urandom);
            o3.ready = ($urandom_range(0, 3) != 0);
            clear3   = ($urandom_range(0, 39) == 0);
            i1.valid = 1'($urandom_range(0, 1));
            i1.data  = 4'($urandom);
            o1.ready = ($urandom_range(0, 2) != 0);
            clear1   = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        clear3 = 0; clear1 = 0;
        drain3();
        drain1();
        @(negedge clk);
        chk("end_occ3", int'(occ3), 0);
        chk("end_occ1", int'(occ1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
